dm_bytewise: RTL and testbench
==============================

# dm_bytewise

Parametrised data memory for the MIPS datapath, successor to the fixed 4 KiB word-only data memory. Adds configurable depth, byte/halfword/word loads and stores with optional sign extension, misalignment detection, a registered (1-cycle) read with request/valid handshake, and an optional zero-clear sweep after reset. Sits between the ALU address output and the write-back mux; the control unit drives size/sign from the load/store opcode.

## Interface
- ADDR_WIDTH, 12, byte-address width; depth = 2^(ADDR_WIDTH-2) 32-bit words (default 1024 words = 4 KiB)
- CLEAR_ON_RESET, 1, 1: zero every word after reset before accepting requests; 0: contents untouched, ready immediately after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  access request, accepted when req && ready at a rising edge
- we  in  1  1 = store, 0 = load (sampled with req)
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- sext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_WIDTH  byte address
- din  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready  out  1  block can accept a request this cycle
- rvalid  out  1  one-cycle pulse: dout holds load result
- dout  out  32  load data, right-aligned and extended
- err  out  1  one-cycle pulse: previous accepted access was misaligned or reserved size

## Operation
- States: INIT (clear sweep), RUN. rst forces INIT with sweep counter 0 if CLEAR_ON_RESET=1, else RUN.
- INIT: each cycle with rst low writes 0 to word[counter], counter++; after word DEPTH-1 is written, go to RUN. ready=0 in INIT; req ignored.
- RUN: ready=1 every cycle; one access per cycle, back-to-back allowed.
- Word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0]; little-endian: byte lane k is bits 8k+7:8k, halfword at lane 0 is [15:0], lane 2 is [31:16].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; size 11 always errors.
- Store (legal): only selected lanes written at acceptance edge, others preserved. Illegal store: no memory change.
- Load (legal): selected lanes extracted, shifted to [7:0]/[15:0], extended per sext; word ignores sext. Illegal load: dout=0.
- Read-during-write: a load issued the cycle after a store to the same word returns the new data; no same-cycle hazard exists (one access per cycle).
- err and rvalid are independent: illegal load gives rvalid=1 and err=1; illegal store gives err=1, rvalid=0; legal store gives neither.

## Timing
- Reset values: ready 0, rvalid 0, err 0, dout 0; INIT counter 0.
- CLEAR_ON_RESET=1: ready rises exactly DEPTH cycles after first edge with rst low (1024 for default). CLEAR_ON_RESET=0: ready=1 at first edge with rst low.
- Load latency 1: accepted at edge N, rvalid/dout/err valid after edge N+1 for one cycle.
- dout holds last load value until the next completed load or reset; rvalid, err are pulses.
- rst asserted mid-sweep: sweep restarts from word 0. rst asserted with a load in flight: rvalid/err suppressed, dout cleared.
- Address bits beyond ADDR_WIDTH are absent; index wraps naturally within depth.

## Test plan
- Reset with CLEAR_ON_RESET=1, then hold req: ready=0 for 1024 cycles, rises at cycle 1024; load word 0x3FC -> dout=0x00000000, rvalid 1 cycle after.
- Store word 0x12345678 at 0x010; load bytes 0x010..0x013 with sext=0 -> 0x78,0x56,0x34,0x12; lh 0x012 sext=1 -> 0x00001234.
- Store byte 0x80 at 0x021 over word 0xAAAAAAAA; lw 0x020 -> 0xAAAA80AA; lb 0x021 sext=1 -> 0xFFFFFF80, sext=0 -> 0x00000080.
- Word store at 0x002, half store at 0x001, size=11 load -> err pulses, memory unchanged, illegal load gives rvalid=1 dout=0.
- Back-to-back: sw 0x040=0xDEADBEEF then lw 0x040 next cycle -> 0xDEADBEEF one cycle later; ready stays 1 throughout.
- Assert rst at sweep cycle 500: ready stays 0 for full 1024 cycles after release; pre-written data read back as 0.

Source files
------------

// File: rtl/dm_bytewise_if.sv
// dm_bytewise_if: request/response bundle for the byte-addressable data memory.
//
// Handshake: a request is taken on a rising clk edge when req && ready are both
// high; we/size/sext/addr/din are sampled on that same edge. Requests offered
// while ready is low are dropped, not held. Responses are not back-pressured.
// rvalid and err are single-cycle pulses, and they appear in the cycle after the
// edge that follows acceptance. dout holds the most recent load result until the
// next load completes or reset clears it.
//
// Signals:
//   req, we, size, sext, addr, din : master -> memory
//   ready, rvalid, dout, err       : memory -> master
interface dm_bytewise_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  sext;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           din;
  logic                  ready;
  logic                  rvalid;
  logic [31:0]           dout;
  logic                  err;

  modport master (
    output req, we, size, sext, addr, din,
    input  ready, rvalid, dout, err
  );

  modport slave (
    input  req, we, size, sext, addr, din,
    output ready, rvalid, dout, err
  );
endinterface

// File: rtl/dm_bytewise.sv
// dm_bytewise: parametrised data memory for the MIPS datapath.
//
// Supports byte, halfword and word loads and stores, with optional sign
// extension on loads. It detects misaligned and reserved-size accesses. Reads are
// registered and complete one cycle after acceptance. If CLEAR_ON_RESET is set,
// the memory zero-clears itself after reset and only then starts taking requests.
//
// Parameters:
//   ADDR_WIDTH     : byte-address width; depth = 2^(ADDR_WIDTH-2) words
//   CLEAR_ON_RESET : 1 = zero every word after reset, 0 = ready right after reset
// Ports:
//   clk       : clock, every state update happens on the rising edge
//   rst       : synchronous, active-high reset
//   bus       : slave side of dm_bytewise_if (req/we/size/sext/addr/din in,
//               ready/rvalid/dout/err out)
//   dbg_state : current FSM state (0 = INIT sweep, 1 = RUN)
module dm_bytewise #(
  parameter int ADDR_WIDTH     = 12,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  dm_bytewise_if.slave  bus,
  output logic          dbg_state
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;

  logic [31:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // FSM: INIT sweeps zeros through the array, and RUN serves requests.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + IW'(1);
        // The last word is written on this edge, so RUN starts right after it.
        if (&cnt_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign dbg_state = (state_q == ST_RUN);

  // ready is gated with rst so that it reads 0 during reset, even in the
  // CLEAR_ON_RESET=0 build where reset already parks the FSM in RUN.
  logic ready;
  assign ready     = (state_q == ST_RUN) && !rst;
  assign bus.ready = ready;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic          accept;
  logic          legal;
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wdata;

  assign accept = bus.req && ready;
  assign idx    = bus.addr[ADDR_WIDTH-1:2];
  assign lane   = bus.addr[1:0];

  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wdata = bus.din;
    case (bus.size)
      SZ_BYTE: begin
        legal = 1'b1;
        be    = 4'b0001 << lane;
        wdata = {4{bus.din[7:0]}};
      end
      SZ_HALF: begin
        legal = !lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.din[15:0]}};
      end
      SZ_WORD: begin
        legal = (lane == 2'b00);
        be    = 4'b1111;
        wdata = bus.din;
      end
      default: begin
        legal = 1'b0;
        be    = 4'b0000;
        wdata = bus.din;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: the clear sweep and legal stores share one write port. The two are
  // exclusive because ready is low for the whole sweep.
  // ---------------------------------------------------------------------------
  logic sweep_we;
  logic store_we;

  assign sweep_we = (state_q == ST_INIT) && !rst;
  assign store_we = accept && bus.we && legal;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= '0;
    end else if (store_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load pipeline.
  // Stage 1 captures the raw word and the access attributes on the acceptance
  // edge. A load that follows a store to the same word reads the updated
  // contents, because the store has already landed by then.
  // Stage 2 extracts, extends and presents the result on the next edge.
  // ---------------------------------------------------------------------------
  logic        p_load_q;
  logic        p_err_q;
  logic        p_legal_q;
  logic [1:0]  p_size_q;
  logic        p_sext_q;
  logic [1:0]  p_lane_q;
  logic [31:0] p_word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_load_q <= 1'b0;
      p_err_q  <= 1'b0;
    end else begin
      p_load_q <= accept && !bus.we;
      p_err_q  <= accept && !legal;
    end
  end

  // The access attributes need no reset, because p_load_q qualifies them.
  always_ff @(posedge clk) begin
    if (accept && !bus.we) begin
      p_word_q  <= mem[idx];
      p_legal_q <= legal;
      p_size_q  <= bus.size;
      p_sext_q  <= bus.sext;
      p_lane_q  <= lane;
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_comb begin
    byte_sel = p_word_q[7:0];
    case (p_lane_q)
      2'd0:    byte_sel = p_word_q[7:0];
      2'd1:    byte_sel = p_word_q[15:8];
      2'd2:    byte_sel = p_word_q[23:16];
      default: byte_sel = p_word_q[31:24];
    endcase
    half_sel = p_lane_q[1] ? p_word_q[31:16] : p_word_q[15:0];

    load_val = '0;
    if (p_legal_q) begin
      case (p_size_q)
        SZ_BYTE: load_val = {{24{p_sext_q & byte_sel[7]}}, byte_sel};
        SZ_HALF: load_val = {{16{p_sext_q & half_sel[15]}}, half_sel};
        SZ_WORD: load_val = p_word_q;
        default: load_val = '0;
      endcase
    end
  end

  logic        rvalid_q;
  logic        err_q;
  logic [31:0] dout_q;

  // A reset that lands while a load is in flight drops the response, because
  // the pipeline flags above are cleared by the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      rvalid_q <= p_load_q;
      err_q    <= p_err_q;
      if (p_load_q) dout_q <= load_val;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.dout   = dout_q;

endmodule

// File: tb/tb_dm_bytewise.sv
// tb_dm_bytewise: directed, self-checking bench for dm_bytewise with the default
// parameters (4 KiB, clear-on-reset). Inputs are driven and outputs are sampled
// on the falling clock edge.
module tb_dm_bytewise;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << (AW - 2);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  always #5 clk = ~clk;

  dm_bytewise_if #(.ADDR_WIDTH(AW)) bus ();

  dm_bytewise #(
    .ADDR_WIDTH(AW),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (each is entered just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [AW-1:0] a, input logic [31:0] d);
    bus.req  = 1'b1;
    bus.we   = w;
    bus.size = sz;
    bus.sext = sx;
    bus.addr = a;
    bus.din  = d;
    @(negedge clk);
    bus.req  = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sx,
                          input logic [AW-1:0] a, input logic [31:0] exp_dout,
                          input logic exp_err);
    issue(1'b0, sz, sx, a, 32'h0);
    check({tag, "_rvalid_early"}, {31'b0, bus.rvalid}, 32'd0);
    @(negedge clk);
    check({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
    check({tag, "_dout"}, bus.dout, exp_dout);
    check({tag, "_err"}, {31'b0, bus.err}, {31'b0, exp_err});
  endtask

  task automatic store_chk(input string tag, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [31:0] d,
                           input logic exp_err);
    issue(1'b1, sz, 1'b0, a, d);
    @(negedge clk);
    check({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd0);
    check({tag, "_err"}, {31'b0, bus.err}, {31'b0, exp_err});
  endtask

  // Entered at the falling edge where rst is released. ready must stay low for
  // DEPTH-1 edges and come up right after the DEPTH-th edge.
  task automatic wait_sweep(input string tag);
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      check({tag, "_ready_low"}, {31'b0, bus.ready}, 32'd0);
      if (i == DEPTH - 1) bus.req = 1'b0;
    end
    @(negedge clk);
    check({tag, "_ready_high"}, {31'b0, bus.ready}, 32'd1);
    check({tag, "_state_run"}, {31'b0, dbg_state}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.req  = 1'b0;
    bus.we   = 1'b0;
    bus.size = 2'b00;
    bus.sext = 1'b0;
    bus.addr = '0;
    bus.din  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_dout", bus.dout, 32'd0);
    check("rst_state_init", {31'b0, dbg_state}, 32'd0);

    // Sweep while a store is held on the bus. The store must be ignored.
    bus.req  = 1'b1;
    bus.we   = 1'b1;
    bus.size = 2'b10;
    bus.addr = 12'h3FC;
    bus.din  = 32'hFFFF_FFFF;
    rst      = 1'b0;
    wait_sweep("sweep1");
    check("sweep1_no_err", {31'b0, bus.err}, 32'd0);
    load_chk("lw_3fc", 2'b10, 1'b0, 12'h3FC, 32'h0000_0000, 1'b0);
    @(negedge clk);
    check("lw_3fc_rvalid_pulse", {31'b0, bus.rvalid}, 32'd0);
    check("lw_3fc_dout_hold", bus.dout, 32'h0000_0000);

    // Byte and halfword extraction from one word
    store_chk("sw_010", 2'b10, 12'h010, 32'h1234_5678, 1'b0);
    load_chk("lbu_010", 2'b00, 1'b0, 12'h010, 32'h0000_0078, 1'b0);
    load_chk("lbu_011", 2'b00, 1'b0, 12'h011, 32'h0000_0056, 1'b0);
    load_chk("lbu_012", 2'b00, 1'b0, 12'h012, 32'h0000_0034, 1'b0);
    load_chk("lbu_013", 2'b00, 1'b0, 12'h013, 32'h0000_0012, 1'b0);
    load_chk("lh_012", 2'b01, 1'b1, 12'h012, 32'h0000_1234, 1'b0);
    load_chk("lh_010", 2'b01, 1'b1, 12'h010, 32'h0000_5678, 1'b0);

    // Partial stores preserve the other lanes
    store_chk("sw_020", 2'b10, 12'h020, 32'hAAAA_AAAA, 1'b0);
    store_chk("sb_021", 2'b00, 12'h021, 32'hFFFF_FF80, 1'b0);
    check("sb_dout_hold", bus.dout, 32'h0000_5678);
    load_chk("lw_020", 2'b10, 1'b1, 12'h020, 32'hAAAA_80AA, 1'b0);
    load_chk("lb_021", 2'b00, 1'b1, 12'h021, 32'hFFFF_FF80, 1'b0);
    load_chk("lbu_021", 2'b00, 1'b0, 12'h021, 32'h0000_0080, 1'b0);
    load_chk("lh_022", 2'b01, 1'b1, 12'h022, 32'hFFFF_AAAA, 1'b0);
    load_chk("lhu_020", 2'b01, 1'b0, 12'h020, 32'h0000_80AA, 1'b0);
    store_chk("sh_022", 2'b01, 12'h022, 32'h9999_5555, 1'b0);
    load_chk("lw_020_b", 2'b10, 1'b0, 12'h020, 32'h5555_80AA, 1'b0);
    store_chk("sb_023", 2'b00, 12'h023, 32'h0000_00C3, 1'b0);
    load_chk("lw_020_c", 2'b10, 1'b0, 12'h020, 32'hC355_80AA, 1'b0);

    // Misaligned and reserved-size accesses
    store_chk("sw_000", 2'b10, 12'h000, 32'hCAFE_F00D, 1'b0);
    store_chk("sw_002_bad", 2'b10, 12'h002, 32'h1111_1111, 1'b1);
    store_chk("sh_001_bad", 2'b01, 12'h001, 32'h0000_2222, 1'b1);
    store_chk("s11_000_bad", 2'b11, 12'h000, 32'h3333_3333, 1'b1);
    check("bad_store_dout_hold", bus.dout, 32'hC355_80AA);
    load_chk("l11_000_bad", 2'b11, 1'b0, 12'h000, 32'h0000_0000, 1'b1);
    @(negedge clk);
    check("err_pulse", {31'b0, bus.err}, 32'd0);
    load_chk("lh_003_bad", 2'b01, 1'b1, 12'h003, 32'h0000_0000, 1'b1);
    load_chk("lw_001_bad", 2'b10, 1'b0, 12'h001, 32'h0000_0000, 1'b1);
    load_chk("lw_000", 2'b10, 1'b0, 12'h000, 32'hCAFE_F00D, 1'b0);

    // Back-to-back store then load of the same word
    bus.req  = 1'b1;
    bus.we   = 1'b1;
    bus.size = 2'b10;
    bus.sext = 1'b0;
    bus.addr = 12'h040;
    bus.din  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("b2b_ready_1", {31'b0, bus.ready}, 32'd1);
    bus.we   = 1'b0;
    bus.din  = 32'h0;
    @(negedge clk);
    bus.req  = 1'b0;
    check("b2b_ready_2", {31'b0, bus.ready}, 32'd1);
    check("b2b_store_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("b2b_store_err", {31'b0, bus.err}, 32'd0);
    @(negedge clk);
    check("b2b_load_rvalid", {31'b0, bus.rvalid}, 32'd1);
    check("b2b_load_dout", bus.dout, 32'hDEAD_BEEF);
    check("b2b_load_err", {31'b0, bus.err}, 32'd0);

    // Reset while a load is in flight drops its response
    store_chk("sw_050", 2'b10, 12'h050, 32'h1357_9BDF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("flight_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("flight_err", {31'b0, bus.err}, 32'd0);
    check("flight_dout", bus.dout, 32'h0000_0000);
    check("flight_ready", {31'b0, bus.ready}, 32'd0);
    rst = 1'b0;

    // A reset in the middle of the sweep restarts it from word 0
    repeat (500) @(negedge clk);
    check("mid_sweep_ready", {31'b0, bus.ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("sweep2");
    load_chk("lw_050_clr", 2'b10, 1'b0, 12'h050, 32'h0000_0000, 1'b0);
    load_chk("lw_010_clr", 2'b10, 1'b0, 12'h010, 32'h0000_0000, 1'b0);
    load_chk("lw_040_clr", 2'b10, 1'b0, 12'h040, 32'h0000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound, so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
